// File: rtl/uart_baud_gen.sv
// uart_baud_gen: baud-rate tick generator with one shared divisor and two
// independent channels (TX bit boundaries; RX mid-bit samples and bit ends).
// Optional fractional divisor accumulation: define UART_BAUD_FRAC_EN.
module uart_baud_gen #(
    parameter int DLY         = 0,
    parameter int DIV_W       = 16,
    parameter int FRAC_W      = 4,
    parameter int DEFAULT_DIV = 434
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              cfg_load,
    input  logic              tx_en,
    input  logic              rx_en,
    output logic              tx_tick,
    output logic              rx_sample,
    output logic              rx_bit_end,
    output logic              cfg_err
);
    localparam int               NCH   = 2;
    localparam int               CH_TX = 0;
    localparam int               CH_RX = 1;
    localparam logic [DIV_W:0]   ONE   = (DIV_W+1)'(1);
    localparam logic [DIV_W:0]   MIN_N = (DIV_W+1)'(2);
    localparam logic [DIV_W-1:0] RST_N = DIV_W'(DEFAULT_DIV);

    // DLY sets a simulation delay for behavioural models; these registers
    // assign with zero delay, so the parameter has no effect on the logic.
    if (DLY < 0) begin : g_dly_negative
    end

    logic [DIV_W-1:0]          act_n_q, act_n_d;
    logic                      cfg_err_q, cfg_err_d;
    logic [DIV_W:0]            n_eff;
    logic [DIV_W:0]            half;
    logic [NCH-1:0]            en;
    logic [NCH-1:0][DIV_W:0]   cnt_q, cnt_d;
    logic [NCH-1:0][DIV_W:0]   per;
    logic [NCH-1:0]            bnd_q, bnd_d;
    logic                      smp_q, smp_d;
`ifdef UART_BAUD_FRAC_EN
    logic [FRAC_W-1:0]         act_f_q, act_f_d;
    logic [NCH-1:0][FRAC_W-1:0] acc_q, acc_d;
    logic [NCH-1:0][FRAC_W:0]  sum;
`else
    logic                      unused_div_frac;
    assign unused_div_frac = ^div_frac;
`endif

    assign en = {rx_en, tx_en};

    // Divisor capture only while both channels are idle; otherwise flag the reject.
    always_comb begin
        act_n_d   = act_n_q;
        cfg_err_d = 1'b0;
`ifdef UART_BAUD_FRAC_EN
        act_f_d   = act_f_q;
`endif
        if (cfg_load) begin
            if (!tx_en && !rx_en) begin
                act_n_d = div_int;
`ifdef UART_BAUD_FRAC_EN
                act_f_d = div_frac;
`endif
            end else begin
                cfg_err_d = 1'b1;
            end
        end
    end

    // Effective integer divisor (0 and 1 clamp to 2) and RX mid-bit point.
    always_comb begin
        n_eff = ({1'b0, act_n_q} < MIN_N) ? MIN_N : {1'b0, act_n_q};
        half  = (n_eff - ONE) >> 1;
    end

    // Per-channel bit counter; period stretches by one clock on accumulator carry.
    always_comb begin
        cnt_d = '0;
        bnd_d = '0;
        per   = '0;
`ifdef UART_BAUD_FRAC_EN
        acc_d = '0;
        sum   = '0;
`endif
        for (int c = 0; c < NCH; c++) begin
`ifdef UART_BAUD_FRAC_EN
            sum[c] = {1'b0, acc_q[c]} + {1'b0, act_f_q};
            per[c] = n_eff + {{DIV_W{1'b0}}, sum[c][FRAC_W]};
`else
            per[c] = n_eff;
`endif
            if (en[c]) begin
                if (cnt_q[c] == per[c] - ONE) begin
                    cnt_d[c] = '0;
                    bnd_d[c] = 1'b1;
`ifdef UART_BAUD_FRAC_EN
                    acc_d[c] = sum[c][FRAC_W-1:0];
`endif
                end else begin
                    cnt_d[c] = cnt_q[c] + ONE;
`ifdef UART_BAUD_FRAC_EN
                    acc_d[c] = acc_q[c];
`endif
                end
            end
        end
        smp_d = en[CH_RX] && (cnt_q[CH_RX] == half);
    end

    // Divisor registers and the registered reject pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_n_q   <= RST_N;
            cfg_err_q <= 1'b0;
`ifdef UART_BAUD_FRAC_EN
            act_f_q   <= '0;
`endif
        end else begin
            act_n_q   <= act_n_d;
            cfg_err_q <= cfg_err_d;
`ifdef UART_BAUD_FRAC_EN
            act_f_q   <= act_f_d;
`endif
        end
    end

    // Channel counters, accumulators and registered output pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            bnd_q <= '0;
            smp_q <= 1'b0;
`ifdef UART_BAUD_FRAC_EN
            acc_q <= '0;
`endif
        end else begin
            cnt_q <= cnt_d;
            bnd_q <= bnd_d;
            smp_q <= smp_d;
`ifdef UART_BAUD_FRAC_EN
            acc_q <= acc_d;
`endif
        end
    end

    assign tx_tick    = bnd_q[CH_TX];
    assign rx_bit_end = bnd_q[CH_RX];
    assign rx_sample  = smp_q;
    assign cfg_err    = cfg_err_q;

endmodule
